// File: rtl/hazard_sequencer.sv
// Hazard and sequencing controller for a 5-stage MIPS pipeline: shadows the EX/MEM/WB
// destination fields and drives stalls, bubbles, flushes, forwarding selects and memory-wait freeze.
module hazard_sequencer #(
    parameter int RA_W     = 5,
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_uses_rt,
    input  logic [RA_W-1:0]  id_dst,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_jump,
    input  logic             ex_br_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_freeze,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             wait_err
);

    localparam int WC_W = $clog2(WAIT_MAX + 1);
    localparam logic [WC_W-1:0] WAIT_TOP  = WC_W'(WAIT_MAX);
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(WAIT_MAX - 1);

    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]      state;
    logic [WC_W-1:0] wait_cnt;

    logic [RA_W-1:0] ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
    logic            ex_rw, ex_mr, mem_rw, wb_rw;
    logic            load_use;

    // A load in EX whose destination feeds the ID instruction; register 0 never hazards.
    assign load_use = ex_mr && (ex_dst != '0) &&
                      ((ex_dst == id_rs) || (id_uses_rt && (ex_dst == id_rt)));

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        if (mem_busy) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            pipe_freeze = 1'b1;
        end else if (ex_br_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            if (load_use) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
            ifid_flush = id_jump;
        end
    end

    // EX/MEM result is newer than MEM/WB, so it takes priority.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (ex_rs != '0) begin
            if (mem_rw && (mem_dst == ex_rs))    fwd_a = 2'b10;
            else if (wb_rw && (wb_dst == ex_rs)) fwd_a = 2'b01;
        end
        if (ex_rt != '0) begin
            if (mem_rw && (mem_dst == ex_rt))    fwd_b = 2'b10;
            else if (wb_rw && (wb_dst == ex_rt)) fwd_b = 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rs   <= '0;
            ex_rt   <= '0;
            ex_dst  <= '0;
            ex_rw   <= 1'b0;
            ex_mr   <= 1'b0;
            mem_dst <= '0;
            mem_rw  <= 1'b0;
            wb_dst  <= '0;
            wb_rw   <= 1'b0;
        end else if (!pipe_freeze) begin
            if (idex_bubble) begin
                ex_rs  <= '0;
                ex_rt  <= '0;
                ex_dst <= '0;
                ex_rw  <= 1'b0;
                ex_mr  <= 1'b0;
            end else begin
                ex_rs  <= id_rs;
                ex_rt  <= id_rt;
                ex_dst <= id_dst;
                ex_rw  <= id_reg_write;
                ex_mr  <= id_mem_read;
            end
            mem_dst <= ex_dst;
            mem_rw  <= ex_rw;
            wb_dst  <= mem_dst;
            wb_rw   <= mem_rw;
        end
    end

    // Wait counter only runs in WAIT; the entering RUN cycle does not count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_RUN;
            wait_cnt <= '0;
            wait_err <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (mem_busy) begin
                        state    <= S_WAIT;
                        wait_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    if (!mem_busy) begin
                        state <= S_RUN;
                    end else begin
                        if (wait_cnt != WAIT_TOP) wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt >= WAIT_LAST) wait_err <= 1'b1;
                    end
                end
                default: state <= S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!pc_write && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: directed vector table plus random traffic checked against
// an instruction-queue model of the hazard, forwarding and memory-wait rules.
module tb_hazard_sequencer;

    localparam int RA_W     = 5;
    localparam int CNT_W    = 4;
    localparam int WAIT_MAX = 4;
    localparam int N_VEC    = 27;
    localparam int N_RAND   = 500;

    // Inputs and outputs are sampled/driven between edges; valid means "this cycle's fields apply".
    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ut;
        logic [4:0] dst;
        logic       rw;
        logic       mr;
        logic       jp;
        logic       br;
        logic       bz;
    } in_t;

    typedef struct packed {
        in_t         stim;
        logic [13:0] exp;
    } vec_t;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
        logic       rw;
        logic       mr;
    } ins_t;

    logic             clk;
    logic             rst_n;
    logic [RA_W-1:0]  id_rs, id_rt, id_dst;
    logic             id_uses_rt, id_reg_write, id_mem_read, id_jump, ex_br_taken, mem_busy;
    logic             pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze;
    logic [1:0]       fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt;
    logic             wait_err;

    int total = 0;
    int bad   = 0;

    logic [13:0] exp_q[$];
    ins_t        pipe[$];
    int          m_stall;
    int          m_run;
    logic        m_err;
    vec_t        tbl[N_VEC];

    hazard_sequencer #(.RA_W(RA_W), .CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_jump(id_jump),
        .ex_br_taken(ex_br_taken), .mem_busy(mem_busy),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .wait_err(wait_err)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic in_t mk_in(int rs, int rt, int ut, int dst, int rw, int mr, int jp, int br, int bz);
        in_t v;
        v.rs = 5'(rs); v.rt = 5'(rt); v.ut = 1'(ut); v.dst = 5'(dst);
        v.rw = 1'(rw); v.mr = 1'(mr); v.jp = 1'(jp); v.br = 1'(br); v.bz = 1'(bz);
        return v;
    endfunction

    function automatic logic [13:0] mk_exp(int pc, int ifw, int fl, int bb, int fz, int fa, int fb, int sc, int er);
        return {1'(pc), 1'(ifw), 1'(fl), 1'(bb), 1'(fz), 2'(fa), 2'(fb), 4'(sc), 1'(er)};
    endfunction

    function automatic logic [13:0] dut_out();
        return {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, fwd_a, fwd_b, stall_cnt, wait_err};
    endfunction

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%b want=%b (pc,ifw,flush,bubble,freeze,fa,fb,stall,err)",
                     name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic ins_t zero_ins();
        ins_t z;
        z.rs = '0; z.rt = '0; z.dst = '0; z.rw = 1'b0; z.mr = 1'b0;
        return z;
    endfunction

    task automatic model_reset();
        pipe.delete();
        for (int i = 0; i < 3; i++) pipe.push_back(zero_ins());
        m_stall = 0;
        m_run   = 0;
        m_err   = 1'b0;
    endtask

    // Newest producer of a non-zero source wins: MEM (pipe[1]) before WB (pipe[2]).
    function automatic logic [1:0] m_fwd(logic [4:0] src);
        if (src == 0) return 2'b00;
        if (pipe[1].rw && pipe[1].dst == src) return 2'b10;
        if (pipe[2].rw && pipe[2].dst == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [13:0] model_out(in_t s);
        logic lu, pc, ifw, fl, bb;
        lu  = pipe[0].mr && pipe[0].dst != 0 &&
              (pipe[0].dst == s.rs || (s.ut && pipe[0].dst == s.rt));
        pc = 1; ifw = 1; fl = 0; bb = 0;
        if (s.bz) begin
            pc = 0; ifw = 0;
        end else if (s.br) begin
            fl = 1; bb = 1;
        end else begin
            if (lu) begin pc = 0; ifw = 0; bb = 1; end
            fl = s.jp;
        end
        return {pc, ifw, fl, bb, s.bz, m_fwd(pipe[0].rs), m_fwd(pipe[0].rt), 4'(m_stall), m_err};
    endfunction

    task automatic model_step(in_t s, logic [13:0] o);
        ins_t n;
        if (!s.bz) begin
            n = zero_ins();
            if (!o[10]) begin
                n.rs = s.rs; n.rt = s.rt; n.dst = s.dst; n.rw = s.rw; n.mr = s.mr;
            end
            pipe.push_front(n);
            void'(pipe.pop_back());
            m_run = 0;
        end else begin
            m_run++;
            if (m_run >= WAIT_MAX + 1) m_err = 1'b1;
        end
        if (!o[13] && m_stall < 15) m_stall++;
    endtask

    // ---------------- driver ----------------
    task automatic drive(in_t s);
        id_rs = s.rs; id_rt = s.rt; id_uses_rt = s.ut; id_dst = s.dst;
        id_reg_write = s.rw; id_mem_read = s.mr; id_jump = s.jp;
        ex_br_taken = s.br; mem_busy = s.bz;
    endtask

    // Entered 1 time unit after a rising edge; leaves at the same phase of the next cycle.
    task automatic run_cycle(in_t s, output logic [13:0] act);
        logic [13:0] e;
        drive(s);
        #3;
        exp_q.push_back(model_out(s));
        act = dut_out();
        e = exp_q.pop_front();
        check("model", act, e);
        model_step(s, e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(string name);
        drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b0;
        #2;
        model_reset();
        check(name, dut_out(), mk_exp(1, 1, 0, 0, 0, 0, 0, 0, 0));
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [13:0] act;
        in_t s;
        int busy_left;

        rst_n = 1'b0;
        drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0));
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_init", dut_out(), mk_exp(1, 1, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // $t1=9 $t2=10 $t3=11 $t4=12 $t5=13
        tbl[0]  = '{mk_in(11, 9, 0, 9, 1, 1, 0, 0, 0),  mk_exp(1, 1, 0, 0, 0, 0, 0, 0, 0)}; // lw $t1
        tbl[1]  = '{mk_in(9, 11, 1, 10, 1, 0, 0, 0, 0), mk_exp(0, 0, 0, 1, 0, 0, 0, 0, 0)}; // add uses $t1: load-use
        tbl[2]  = '{mk_in(9, 11, 1, 10, 1, 0, 0, 0, 0), mk_exp(1, 1, 0, 0, 0, 0, 0, 1, 0)};
        tbl[3]  = '{mk_in(10, 11, 1, 9, 1, 0, 0, 0, 0), mk_exp(1, 1, 0, 0, 0, 1, 0, 1, 0)}; // add in EX gets lw via WB
        tbl[4]  = '{mk_in(9, 9, 1, 12, 1, 0, 0, 0, 0),  mk_exp(1, 1, 0, 0, 0, 2, 0, 1, 0)};
        tbl[5]  = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0),   mk_exp(1, 1, 0, 0, 0, 2, 2, 1, 0)}; // sub $t4,$t1,$t1
        tbl[6]  = '{mk_in(10, 11, 1, 9, 1, 0, 0, 0, 0), mk_exp(1, 1, 0, 0, 0, 0, 0, 1, 0)};
        tbl[7]  = '{mk_in(10, 11, 1, 9, 1, 0, 0, 0, 0), mk_exp(1, 1, 0, 0, 0, 0, 0, 1, 0)};
        tbl[8]  = '{mk_in(9, 0, 1, 13, 1, 0, 0, 0, 0),  mk_exp(1, 1, 0, 0, 0, 0, 0, 1, 0)};
        tbl[9]  = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0),   mk_exp(1, 1, 0, 0, 0, 2, 0, 1, 0)}; // newest wins, $0 no fwd
        tbl[10] = '{mk_in(11, 0, 0, 0, 1, 0, 0, 0, 0),  mk_exp(1, 1, 0, 0, 0, 0, 0, 1, 0)}; // write to $0
        tbl[11] = '{mk_in(0, 0, 1, 10, 1, 0, 0, 0, 0),  mk_exp(1, 1, 0, 0, 0, 0, 0, 1, 0)};
        tbl[12] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0),   mk_exp(1, 1, 0, 0, 0, 0, 0, 1, 0)};
        tbl[13] = '{mk_in(11, 9, 0, 9, 1, 1, 0, 0, 0),  mk_exp(1, 1, 0, 0, 0, 0, 0, 1, 0)}; // lw $t1
        tbl[14] = '{mk_in(9, 11, 1, 10, 1, 0, 0, 1, 0), mk_exp(1, 1, 1, 1, 0, 0, 0, 1, 0)}; // branch beats load-use
        tbl[15] = '{mk_in(0, 0, 0, 0, 0, 0, 1, 0, 0),   mk_exp(1, 1, 1, 0, 0, 0, 0, 1, 0)}; // jump
        tbl[16] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1),   mk_exp(0, 0, 0, 0, 1, 0, 0, 1, 0)};
        tbl[17] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1),   mk_exp(0, 0, 0, 0, 1, 0, 0, 2, 0)};
        tbl[18] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1),   mk_exp(0, 0, 0, 0, 1, 0, 0, 3, 0)};
        tbl[19] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0),   mk_exp(1, 1, 0, 0, 0, 0, 0, 4, 0)};
        tbl[20] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1),   mk_exp(0, 0, 0, 0, 1, 0, 0, 4, 0)}; // 6-cycle busy
        tbl[21] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1),   mk_exp(0, 0, 0, 0, 1, 0, 0, 5, 0)};
        tbl[22] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1),   mk_exp(0, 0, 0, 0, 1, 0, 0, 6, 0)};
        tbl[23] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1),   mk_exp(0, 0, 0, 0, 1, 0, 0, 7, 0)};
        tbl[24] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1),   mk_exp(0, 0, 0, 0, 1, 0, 0, 8, 0)};
        tbl[25] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1),   mk_exp(0, 0, 0, 0, 1, 0, 0, 9, 1)};
        tbl[26] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0),   mk_exp(1, 1, 0, 0, 0, 0, 0, 10, 1)};

        for (int i = 0; i < N_VEC; i++) begin
            run_cycle(tbl[i].stim, act);
            check($sformatf("vec%0d", i), act, tbl[i].exp);
        end

        // Reset while frozen with a sticky error: everything returns to reset values.
        run_cycle(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1), act);
        do_reset("reset_mid_wait");
        run_cycle(mk_in(0, 0, 0, 0, 0, 0, 1, 0, 0), act);
        check("post_reset_jump", act, mk_exp(1, 1, 1, 0, 0, 0, 0, 0, 0));

        busy_left = 0;
        for (int i = 0; i < N_RAND; i++) begin
            if (i == N_RAND / 2) do_reset("reset_rand");
            s = mk_in($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                      $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 0);
            if (busy_left > 0) begin
                s.bz = 1'b1;
                busy_left--;
            end else if ($urandom_range(0, 9) == 0) begin
                s.bz = 1'b1;
                busy_left = $urandom_range(0, 6);
            end
            run_cycle(s, act);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
